// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 32-bit RISC fetch stage.
// Issues req/ack fetches and reports each accepted PC one cycle later.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] pc_plus_step,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] target_aligned;
  logic        accept;
  logic        misaligned;

  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign misaligned     = redirect & |redirect_target[1:0];

  // a same-cycle redirect discards the returned instruction
  assign accept = (state == REQ) & imem_ack & ~redirect;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, HOLD, FLUSH: begin
        state_next = stall ? HOLD : REQ;
      end
      REQ: begin
        if (imem_ack)
          state_next = stall ? HOLD : REQ;
      end
    endcase
    if (redirect)
      state_next = FLUSH;
  end

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      redirect: pc_next = target_aligned;
      accept:   pc_next = pc + STEP;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_pc     <= RESET_PC;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      instr_valid  <= accept;
      misalign_err <= misaligned;
      if (accept)
        fetch_pc <= pc;
    end
  end

  assign imem_req     = (state == REQ);
  assign imem_addr    = pc;
  assign pc_plus_step = pc + STEP;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table plus randomized run against a rule-level
// reference model of the fetch sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus_step;
  logic        misalign_err;

  int n_vec;
  int n_bad;

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .fetch_pc        (fetch_pc),
    .pc_plus_step    (pc_plus_step),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        a;
    logic        s;
    logic        d;
    logic [31:0] t;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] fpc;
    logic        me;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic a, input logic s,
    input logic d, input logic [31:0] t,
    input logic req, input logic [31:0] addr,
    input logic iv, input logic [31:0] fpc,
    input logic me);
    vec_t v;
    v.r = r; v.a = a; v.s = s; v.d = d; v.t = t;
    v.req = req; v.addr = addr; v.iv = iv;
    v.fpc = fpc; v.me = me;
    return v;
  endfunction

  // Reference model: phases named after the spec's operating modes
  typedef enum {M_IDLE, M_FETCH, M_HOLD, M_FLUSH} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic        m_iv;
  logic        m_me;

  task automatic model_step(
    input logic r, input logic a, input logic s,
    input logic d, input logic [31:0] t);
    if (!r) begin
      m_mode = M_IDLE;
      m_pc   = 32'h0;
      m_fpc  = 32'h0;
      m_iv   = 1'b0;
      m_me   = 1'b0;
    end else begin
      m_me = d && (t % 4 != 0);
      m_iv = 1'b0;
      if (d) begin
        m_pc   = t - (t % 4);
        m_mode = M_FLUSH;
      end else if (m_mode == M_FETCH) begin
        if (a) begin
          m_fpc  = m_pc;
          m_pc   = m_pc + 32'd4;
          m_iv   = 1'b1;
          m_mode = s ? M_HOLD : M_FETCH;
        end
      end else begin
        m_mode = s ? M_HOLD : M_FETCH;
      end
    end
  endtask

  task automatic drive(
    input logic r, input logic a, input logic s,
    input logic d, input logic [31:0] t);
    rst_n           = r;
    imem_ack        = a;
    stall           = s;
    redirect        = d;
    redirect_target = t;
  endtask

  task automatic check(
    input string name, input int idx,
    input logic req, input logic [31:0] addr,
    input logic iv, input logic [31:0] fpc,
    input logic me);
    logic [31:0] pps;
    pps = addr + 32'd4;
    n_vec++;
    if (imem_req !== req || imem_addr !== addr ||
        instr_valid !== iv || fetch_pc !== fpc ||
        pc_plus_step !== pps || misalign_err !== me) begin
      n_bad++;
      $display("FAIL %s #%0d: got req=%0b addr=%h iv=%0b fpc=%h pps=%h me=%0b want req=%0b addr=%h iv=%0b fpc=%h pps=%h me=%0b",
        name, idx, imem_req, imem_addr, instr_valid,
        fetch_pc, pc_plus_step, misalign_err,
        req, addr, iv, fpc, pps, me);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // reset / startup, ack tied high
    tbl.push_back(mk(0,1,0,0,0,        0,32'h0,0,32'h0,0));
    tbl.push_back(mk(0,1,0,0,0,        0,32'h0,0,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'h0,0,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h0,0,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h4,1,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h8,1,32'h4,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'hC,1,32'h8,0));
    // stall on the ack of 0x10
    tbl.push_back(mk(1,1,1,0,0,        1,32'h10,1,32'hC,0));
    tbl.push_back(mk(1,1,1,0,0,        0,32'h14,1,32'h10,0));
    tbl.push_back(mk(1,1,1,0,0,        0,32'h14,0,32'h10,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'h14,0,32'h10,0));
    // stall ignored while request outstanding
    tbl.push_back(mk(1,0,1,0,0,        1,32'h14,0,32'h10,0));
    tbl.push_back(mk(1,0,1,1,32'h40,   1,32'h14,0,32'h10,0));
    tbl.push_back(mk(1,0,0,0,0,        0,32'h40,0,32'h10,0));
    // redirect collides with ack at 0x40
    tbl.push_back(mk(1,1,0,1,32'h200,  1,32'h40,0,32'h10,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'h200,0,32'h10,0));
    // misaligned redirect
    tbl.push_back(mk(1,1,0,1,32'h103,  1,32'h200,0,32'h10,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'h100,0,32'h10,1));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h100,0,32'h10,0));
    // wrap
    tbl.push_back(mk(1,1,0,1,32'hFFFF_FFFC, 1,32'h104,1,32'h100,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'hFFFF_FFFC,0,32'h100,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'hFFFF_FFFC,0,32'h100,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h0,1,32'hFFFF_FFFC,0));
    // reset mid-request
    tbl.push_back(mk(1,0,0,0,0,        1,32'h4,1,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,        1,32'h4,0,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        0,32'h0,0,32'h0,0));
    tbl.push_back(mk(1,1,0,0,0,        1,32'h0,0,32'h0,0));
    // redirect inside FLUSH, then FLUSH -> HOLD
    tbl.push_back(mk(1,0,0,1,32'h80,   1,32'h4,1,32'h0,0));
    tbl.push_back(mk(1,0,1,1,32'h90,   0,32'h80,0,32'h0,0));
    tbl.push_back(mk(1,0,1,0,0,        0,32'h90,0,32'h0,0));
    tbl.push_back(mk(1,0,0,0,0,        0,32'h90,0,32'h0,0));
    tbl.push_back(mk(1,0,0,0,0,        1,32'h90,0,32'h0,0));

    drive(0, 1, 0, 0, 0);
    @(posedge clk);
    model_step(0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].t);
      check("dir", i, tbl[i].req, tbl[i].addr,
            tbl[i].iv, tbl[i].fpc, tbl[i].me);
      @(posedge clk);
      model_step(tbl[i].r, tbl[i].a, tbl[i].s,
                 tbl[i].d, tbl[i].t);
    end

    for (int k = 0; k < 3000; k++) begin
      logic        r, a, s, d;
      logic [31:0] t;
      r = ($urandom_range(63) != 0);
      a = ($urandom_range(3) != 0);
      s = ($urandom_range(3) == 0);
      d = ($urandom_range(15) == 0);
      t = $urandom;
      if ($urandom_range(7) == 0)
        t = 32'hFFFF_FFFC | (t & 32'h3);
      @(negedge clk);
      drive(r, a, s, d, t);
      check("rnd", k, (m_mode == M_FETCH), m_pc,
            m_iv, m_fpc, m_me);
      @(posedge clk);
      model_step(r, a, s, d, t);
    end

    @(negedge clk);
    check("end", 0, (m_mode == M_FETCH), m_pc,
          m_iv, m_fpc, m_me);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 32-bit RISC fetch stage. It holds the architectural PC and issues fetch requests to instruction memory over a req/ack handshake. On each accepted fetch it advances the PC by STEP and reports the fetched PC one cycle later. Stall and branch/jump redirect requests from the decode/execute side control it.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STEP, 32'd4, increment applied per accepted fetch.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equal to the internal pc register.
- imem_ack  in  1  memory accepted/returned the fetch at imem_addr this cycle; only meaningful while imem_req=1.
- stall  in  1  pipeline hold request from downstream.
- redirect  in  1  branch/jump taken; highest priority.
- redirect_target  in  32  new PC, valid when redirect=1.
- instr_valid  out  1  registered pulse: the instruction fetched in the previous cycle is valid for decode.
- fetch_pc  out  32  PC of the instruction flagged by instr_valid.
- pc_plus_step  out  32  combinational pc + STEP, modulo 2^32, for link-register use.
- misalign_err  out  1  one-cycle pulse: redirect_target[1:0] was non-zero.

## Operation
- States: IDLE, REQ, HOLD, FLUSH. imem_req=1 only in REQ.
- Reset: rst_n=0 at an edge sets state=IDLE, pc=RESET_PC, fetch_pc=RESET_PC, instr_valid=0, misalign_err=0. Consequently imem_req=0 and imem_addr=RESET_PC. Reset overrides every other input.
- IDLE:
  - Always lasts exactly one cycle.
  - Goes to HOLD if stall=1, else REQ.
  - If redirect=1, pc loads the target and the state goes to FLUSH.
- REQ: imem_addr is held stable until ack or redirect.
  - imem_ack=1, redirect=0: pc <= pc+STEP, fetch_pc <= pc, instr_valid <= 1. Next state is HOLD if stall=1, else REQ.
  - imem_ack=0, redirect=0: stay in REQ; stall is ignored while a request is outstanding.
- HOLD: imem_req=0, pc unchanged. Goes to REQ when stall=0.
- Redirect, in any non-reset state:
  - pc <= {redirect_target[31:2], 2'b00}, state <= FLUSH, instr_valid <= 0.
  - A same-cycle imem_ack is discarded: the instruction is dropped and pc is not incremented.
- misalign_err <= (redirect & |redirect_target[1:0]). The aligned address is still used.
- FLUSH:
  - One cycle with imem_req=0, for memory-side cancellation.
  - Then goes to HOLD if stall=1, else REQ.
  - A new redirect in FLUSH reloads pc and stays in FLUSH.
- instr_valid is 0 in every cycle not immediately preceded by an accepted, non-redirected ack.
- Arithmetic: all additions are 32-bit unsigned and wrap. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Timing
- Ack at edge n gives instr_valid=1 and fetch_pc=old pc in cycle n+1. The next imem_addr=old pc+STEP is also presented in cycle n+1.
- Throughput: one fetch per cycle while imem_ack=1 and stall=0.
- Redirect sampled at edge n: FLUSH in cycle n+1, first request at the target in cycle n+2.
- Reset release: first imem_req=1 occurs 1 cycle after the first edge with rst_n=1 (IDLE cycle).
- Stall deasserted at edge n from HOLD gives imem_req=1 in cycle n+1.
- pc_plus_step and imem_addr are combinational from registers, with no input-to-output paths.

## Test plan
- Reset/startup: rst_n=0 for 3 cycles, then 1, with ack tied 1. Required: req=0 and addr=0 during reset and the IDLE cycle. Then addr is 0, 4, 8 on consecutive cycles; instr_valid with fetch_pc 0, 4, 8 follows one cycle later.
- Stall: stall=1 on the cycle ack accepts addr 0x10. Required: instr_valid with fetch_pc=0x10 next cycle, then req=0 for as long as stall holds. After release, req resumes at 0x14 one cycle later.
- Redirect collision: redirect=1, target=0x200 in the same cycle ack=1 at addr 0x40. Required: no instr_valid for 0x40, one FLUSH cycle with req=0, then a request at 0x200.
- Misaligned redirect: target=0x0000_0103. Required: misalign_err pulses for 1 cycle; the next request is at 0x100.
- Wrap: redirect to 0xFFFF_FFFC with ack held high. Required: fetch at 0xFFFF_FFFC, then 0x0000_0000, and pc_plus_step=0x0 while pc=0xFFFF_FFFC.
- Reset mid-request: in REQ with ack=0, drive rst_n=0 for one edge. Required: req=0 and addr=RESET_PC the next cycle, no instr_valid, and normal restart through IDLE.
